// File: rtl/quan_pipe_v2.sv
// quan_pipe_v2: five-stage requantiser turning signed conv accumulators into saturated
// 8-bit activations, with a per-group parameter table and valid/ready backpressure.
module quan_pipe_v2 #(
  parameter int PIX_NUM = 4,
  parameter int CH_OUT  = 8,
  parameter int ACC_W   = 32,
  parameter int GROUPS  = 8,
  parameter int OUT_W   = 8,
  localparam int GW     = $clog2(GROUPS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [GW-1:0]                    grp_num_cfg,
  input  logic                             prm_we,
  input  logic [1:0]                       prm_sel,
  input  logic [GW-1:0]                    prm_addr,
  input  logic [CH_OUT*32-1:0]             prm_data,
  input  logic [7:0]                       zero_point,
  input  logic [1:0]                       act_mode,
  input  logic [7:0]                       leaky_coef,
  input  logic                             s_valid,
  input  logic [ACC_W*PIX_NUM*CH_OUT-1:0]  s_data,
  output logic                             s_ready,
  output logic                             m_valid,
  output logic [OUT_W*PIX_NUM*CH_OUT-1:0]  m_data,
  input  logic                             m_ready
);

  localparam int LANES = PIX_NUM * CH_OUT;
  localparam int BW    = ((ACC_W > 32) ? ACC_W : 32) + 1;
  localparam int PW    = BW + 32;

  localparam logic signed [PW:0] R_MAX = (PW+1)'(32767);
  localparam logic signed [PW:0] R_MIN = (PW+1)'(-32768);
  localparam logic signed [18:0] O_MAX = 19'((2**OUT_W) - 1);

  typedef enum logic [1:0] {SEL_BIAS, SEL_SCALE, SEL_SHIFT, SEL_NONE} sel_e;
  typedef enum logic [1:0] {ACT_NONE, ACT_RELU, ACT_LEAKY, ACT_RSVD} act_e;

  logic [31:0] r_bias_t  [GROUPS][CH_OUT];
  logic [31:0] r_scale_t [GROUPS][CH_OUT];
  logic [5:0]  r_shift_t [GROUPS][CH_OUT];

  logic [GW-1:0] r_g;
  logic [GW-1:0] w_g_use;
  logic          w_en;
  logic          w_accept;
  logic          r_v1, r_v2, r_v3, r_v4, r_m_valid;

  assign w_en     = !r_m_valid || m_ready;
  assign s_ready  = rst && w_en;
  assign w_accept = s_valid && s_ready;
  assign w_g_use  = start ? '0 : r_g;
  assign m_valid  = r_m_valid;

  // NOTE: the table is a register array that must come up zeroed, so it takes the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int gi = 0; gi < GROUPS; gi++) begin
        for (int k = 0; k < CH_OUT; k++) begin
          r_bias_t[gi][k]  <= '0;
          r_scale_t[gi][k] <= '0;
          r_shift_t[gi][k] <= '0;
        end
      end
    end else if (prm_we) begin
      for (int k = 0; k < CH_OUT; k++) begin
        case (sel_e'(prm_sel))
          SEL_BIAS:  r_bias_t[prm_addr][k]  <= prm_data[32*k +: 32];
          SEL_SCALE: r_scale_t[prm_addr][k] <= prm_data[32*k +: 32];
          SEL_SHIFT: r_shift_t[prm_addr][k] <= prm_data[32*k +: 6];
          default: ;
        endcase
      end
    end
  end

  // Group pointer advances only on accepted beats; a start pulse restarts it at group 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g <= '0;
    end else if (w_accept) begin
      r_g <= (w_g_use >= grp_num_cfg) ? '0 : GW'(w_g_use + 1'b1);
    end else if (start) begin
      r_g <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_v4      <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_en) begin
      r_v1      <= w_accept;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      r_v4      <= r_v3;
      r_m_valid <= r_v4;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int K = l / PIX_NUM;

    logic [ACC_W-1:0]      w_acc_raw;
    logic [31:0]           w_bias;
    logic signed [BW-1:0]  w_b;
    logic signed [PW-1:0]  w_p;
    logic signed [PW:0]    w_ext, w_half, w_shr;
    logic signed [15:0]    w_r;
    logic signed [24:0]    w_lk;
    logic signed [17:0]    w_a;
    logic signed [18:0]    w_o;
    logic [OUT_W-1:0]      w_o_sat;

    logic signed [BW-1:0]  r_b;
    logic signed [31:0]    r_scale;
    logic [5:0]            r_sh1, r_sh2;
    logic signed [PW-1:0]  r_p;
    logic signed [15:0]    r_r;
    logic signed [17:0]    r_a;
    logic [OUT_W-1:0]      r_o;

    assign w_acc_raw = s_data[ACC_W*l +: ACC_W];
    assign w_bias    = r_bias_t[w_g_use][K];
    assign w_b = $signed({{(BW-ACC_W){w_acc_raw[ACC_W-1]}}, w_acc_raw})
               + $signed({{(BW-32){w_bias[31]}}, w_bias});
    assign w_p = PW'(r_b) * PW'(r_scale);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
      w_ext  = {r_p[PW-1], r_p};
      w_half = '0;
      if (r_sh2 != 6'd0) w_half = (PW+1)'(1) << (r_sh2 - 6'd1);
      w_shr = (w_ext + w_half) >>> r_sh2;
      if (w_shr > R_MAX)      w_r = 16'sh7FFF;
      else if (w_shr < R_MIN) w_r = 16'sh8000;
      else                    w_r = w_shr[15:0];
    end

    always_comb begin
      w_lk = 25'(r_r) * 25'($signed({1'b0, leaky_coef}));
      case (act_e'(act_mode))
        ACT_RELU:  w_a = r_r[15] ? '0 : 18'(r_r);
        ACT_LEAKY: w_a = r_r[15] ? 18'((w_lk + 25'sd64) >>> 7) : 18'(r_r);
        default:   w_a = 18'(r_r);
      endcase
    end

    always_comb begin
      w_o = 19'(r_a) + 19'($signed({1'b0, zero_point}));
      if (w_o[18])          w_o_sat = '0;
      else if (w_o > O_MAX) w_o_sat = '1;
      else                  w_o_sat = w_o[OUT_W-1:0];
    end

    // NOTE: interior datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
      if (w_en) begin
        r_b     <= w_b;
        r_scale <= r_scale_t[w_g_use][K];
        r_sh1   <= r_shift_t[w_g_use][K];
        r_p     <= w_p;
        r_sh2   <= r_sh1;
        r_r     <= w_r;
        r_a     <= w_a;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      r_o <= '0;
      else if (w_en) r_o <= w_o_sat;
    end

    assign m_data[OUT_W*l +: OUT_W] = r_o;
  end

endmodule

// File: tb/tb_quan_pipe_v2.sv
// Directed bench for quan_pipe_v2: math, saturation, lane mapping, group cycling,
// backpressure streaming, parameter-write hazard and mid-stream reset.
module tb_quan_pipe_v2;

  localparam int PIX_NUM = 4;
  localparam int CH_OUT  = 8;
  localparam int ACC_W   = 32;
  localparam int GROUPS  = 8;
  localparam int OUT_W   = 8;
  localparam int GW      = 3;
  localparam int LANES   = PIX_NUM * CH_OUT;
  localparam int DW      = ACC_W * LANES;
  localparam int OW      = OUT_W * LANES;
  localparam int PRW     = CH_OUT * 32;

  typedef struct {
    int acc; int bias; int scale; int shift; int zp; int mode; int coef; int exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [GW-1:0]  grp_num_cfg = '0;
  logic           prm_we = 1'b0;
  logic [1:0]     prm_sel = '0;
  logic [GW-1:0]  prm_addr = '0;
  logic [PRW-1:0] prm_data = '0;
  logic [7:0]     zero_point = '0;
  logic [1:0]     act_mode = '0;
  logic [7:0]     leaky_coef = '0;
  logic           s_valid = 1'b0;
  logic [DW-1:0]  s_data = '0;
  logic           s_ready;
  logic           m_valid;
  logic [OW-1:0]  m_data;
  logic           m_ready = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  quan_pipe_v2 #(
    .PIX_NUM(PIX_NUM), .CH_OUT(CH_OUT), .ACC_W(ACC_W), .GROUPS(GROUPS), .OUT_W(OUT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .grp_num_cfg(grp_num_cfg),
    .prm_we(prm_we), .prm_sel(prm_sel), .prm_addr(prm_addr), .prm_data(prm_data),
    .zero_point(zero_point), .act_mode(act_mode), .leaky_coef(leaky_coef),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [DW-1:0] fill_acc(input int v);
    logic [DW-1:0] d;
    for (int l = 0; l < LANES; l++) d[ACC_W*l +: ACC_W] = 32'(v);
    return d;
  endfunction

  function automatic logic [OW-1:0] fill_out(input int v);
    logic [OW-1:0] o;
    for (int l = 0; l < LANES; l++) o[OUT_W*l +: OUT_W] = 8'(v);
    return o;
  endfunction

  function automatic logic [PRW-1:0] fill_words(input int w);
    logic [PRW-1:0] d;
    for (int k = 0; k < CH_OUT; k++) d[32*k +: 32] = 32'(w);
    return d;
  endfunction

  // Stream beat i: lane l carries i-100+l and lands in group i%4 (bias 10*group).
  function automatic logic [DW-1:0] stream_acc(input int i);
    logic [DW-1:0] d;
    for (int l = 0; l < LANES; l++) d[ACC_W*l +: ACC_W] = 32'(i - 100 + l);
    return d;
  endfunction

  function automatic logic [OW-1:0] stream_out(input int i);
    logic [OW-1:0] o;
    for (int l = 0; l < LANES; l++) o[OUT_W*l +: OUT_W] = clamp8(i - 100 + l + 10 * (i % 4));
    return o;
  endfunction

  task automatic write_prm(input logic [1:0] sel, input int addr, input logic [PRW-1:0] words);
    prm_we = 1'b1; prm_sel = sel; prm_addr = GW'(addr); prm_data = words;
    @(posedge clk); #1;
    prm_we = 1'b0;
  endtask

  task automatic set_row(input int addr, input int b, input int sc, input int sh);
    write_prm(2'd0, addr, fill_words(b));
    write_prm(2'd1, addr, fill_words(sc));
    write_prm(2'd2, addr, fill_words(sh));
  endtask

  task automatic apply_vec(input vec_t v);
    grp_num_cfg = '0;
    set_row(0, v.bias, v.scale, v.shift);
    zero_point = 8'(v.zp); act_mode = 2'(v.mode); leaky_coef = 8'(v.coef);
  endtask

  // One beat with an idle pipeline; lat counts edges from acceptance to m_valid.
  task automatic send_get(input logic [DW-1:0] d, input logic st,
                          output logic [OW-1:0] res, output int lat);
    m_ready = 1'b1; s_valid = 1'b1; s_data = d; start = st;
    @(posedge clk); #1;
    s_valid = 1'b0; start = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = m_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; #1; rst = 1'b0; #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== '0) $display("FAIL reset_m_data: got %h want 0", m_data); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else n_pass++;
    @(negedge clk); rst = 1'b1; #1;
    n_total++; if (s_ready !== 1'b1) $display("FAIL release_s_ready: got %b want 1", s_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [OW-1:0] res; int lat;
    vec_t v = '{28, 2, 3, 1, 10, 0, 0, 55};
    apply_vec(v);
    send_get(fill_acc(v.acc), 1'b0, res, lat);
    n_total++; if (lat != 5) $display("FAIL basic_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (res !== fill_out(55)) $display("FAIL basic_data: got %h want all 55", res); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL basic_single_beat: m_valid %b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_rounding();
    logic [OW-1:0] res; int lat;
    vec_t v [10] = '{
      '{1, 0, 3, 1, 0, 0, 0, 2},
      '{-5, 0, 1, 0, 10, 0, 0, 5},
      '{-5, 0, 1, 0, 10, 1, 0, 10},
      '{-5, 0, 1, 0, 10, 2, 13, 9},
      '{-5, 0, 1, 0, 10, 3, 0, 5},
      '{-3, 0, 1, 1, 10, 0, 0, 9},
      '{5, 0, 1, 2, 0, 0, 0, 1},
      '{6, 0, 1, 2, 0, 0, 0, 2},
      '{10, 0, -2, 0, 30, 0, 0, 10},
      '{-100, 0, 1, 0, 60, 2, 64, 10}
    };
    for (int i = 0; i < 10; i++) begin
      apply_vec(v[i]);
      send_get(fill_acc(v[i].acc), 1'b0, res, lat);
      n_total++;
      if (res !== fill_out(v[i].exp)) $display("FAIL rounding[%0d]: got %h want all %0d", i, res, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic [OW-1:0] res; int lat;
    // Third row: ~(2^63)/2^63 rounds to 1; a 64-bit wrap would go negative and clamp to 0.
    vec_t v [5] = '{
      '{40000, 0, 1, 0, 0, 0, 0, 255},
      '{-40000, 0, 1, 0, 0, 0, 0, 0},
      '{2147483647, 2147483647, 2147483647, 63, 0, 0, 0, 1},
      '{250, 0, 1, 0, 10, 0, 0, 255},
      '{-40000, 0, 1, 0, 255, 2, 128, 0}
    };
    for (int i = 0; i < 5; i++) begin
      apply_vec(v[i]);
      send_get(fill_acc(v[i].acc), 1'b0, res, lat);
      n_total++;
      if (res !== fill_out(v[i].exp)) $display("FAIL saturation[%0d]: got %h want all %0d", i, res, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_channels();
    logic [OW-1:0] res, e; logic [DW-1:0] d; logic [PRW-1:0] wb, ws; int lat, k;
    for (int c = 0; c < CH_OUT; c++) begin
      wb[32*c +: 32] = 32'(5 * c);
      ws[32*c +: 32] = 32'(c % 2 + 1);
    end
    grp_num_cfg = '0; zero_point = 8'd0; act_mode = 2'd0;
    write_prm(2'd0, 0, wb);
    write_prm(2'd1, 0, ws);
    write_prm(2'd2, 0, fill_words(0));
    write_prm(2'd3, 0, fill_words(99));
    for (int l = 0; l < LANES; l++) begin
      k = l / PIX_NUM;
      d[ACC_W*l +: ACC_W] = 32'(l - 3);
      e[OUT_W*l +: OUT_W] = clamp8((l - 3 + 5 * k) * (k % 2 + 1));
    end
    send_get(d, 1'b0, res, lat);
    n_total++; if (res !== e) $display("FAIL channels: got %h want %h", res, e); else n_pass++;
  endtask

  task automatic test_groups();
    logic [OW-1:0] res; int lat;
    int exp7 [7] = '{0, 10, 20, 30, 0, 10, 20};
    int st5 [5]  = '{0, 1, 0, 1, 0};
    int cfg5 [5] = '{3, 3, 3, 0, 0};
    int exp5 [5] = '{0, 0, 10, 0, 0};
    grp_num_cfg = GW'(3); zero_point = 8'd0; act_mode = 2'd0;
    for (int g = 0; g < 4; g++) set_row(g, 10 * g, 1, 0);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      send_get(fill_acc(0), 1'b0, res, lat);
      n_total++;
      if (res !== fill_out(exp7[b])) $display("FAIL groups_cycle[%0d]: got %h want all %0d", b, res, exp7[b]);
      else n_pass++;
    end
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      grp_num_cfg = GW'(cfg5[b]);
      send_get(fill_acc(0), 1'(st5[b]), res, lat);
      n_total++;
      if (res !== fill_out(exp5[b])) $display("FAIL groups_start[%0d]: got %h want all %0d", b, res, exp5[b]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int sent, rcvd, cyc, extra;
    logic held; logic [OW-1:0] hd, e;
    grp_num_cfg = GW'(3); zero_point = 8'd0; act_mode = 2'd0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    sent = 0; rcvd = 0; cyc = 0; held = 1'b0; hd = '0;
    while (rcvd < 200 && cyc < 4000) begin
      m_ready = 1'($urandom_range(0, 1));
      s_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
      s_data  = stream_acc(sent);
      @(negedge clk);
      if (held) begin
        n_total++;
        if (m_valid !== 1'b1 || m_data !== hd)
          $display("FAIL stall_hold: m_valid %b m_data %h want 1 %h", m_valid, m_data, hd);
        else n_pass++;
      end
      if (m_valid && m_ready) begin
        e = stream_out(rcvd);
        n_total++;
        if (m_data !== e) $display("FAIL stream[%0d]: got %h want %h", rcvd, m_data, e);
        else n_pass++;
        rcvd++;
      end
      held = m_valid && !m_ready;
      hd   = m_data;
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    n_total++; if (rcvd != 200) $display("FAIL stream_count: got %0d want 200 in budget", rcvd); else n_pass++;
    extra = 0;
    repeat (8) begin @(posedge clk); #1; if (m_valid) extra++; end
    n_total++; if (extra != 0) $display("FAIL stream_extra: got %0d extra beats want 0", extra); else n_pass++;
  endtask

  task automatic test_hazard();
    int got, t0, t1; logic [OW-1:0] o0, o1;
    grp_num_cfg = '0; zero_point = 8'd0; act_mode = 2'd0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    set_row(0, 0, 1, 0);
    m_ready = 1'b1; s_valid = 1'b1; s_data = fill_acc(5);
    prm_we = 1'b1; prm_sel = 2'd0; prm_addr = '0; prm_data = fill_words(7);
    @(posedge clk); #1;
    prm_we = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    got = 0; t0 = 0; t1 = 0; o0 = '0; o1 = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_valid) begin
        if (got == 0) begin o0 = m_data; t0 = c; end
        else if (got == 1) begin o1 = m_data; t1 = c; end
        got++;
      end
    end
    n_total++; if (got != 2) $display("FAIL hazard_count: got %0d want 2", got); else n_pass++;
    n_total++; if (o0 !== fill_out(5)) $display("FAIL hazard_old_bias: got %h want all 5", o0); else n_pass++;
    n_total++; if (o1 !== fill_out(12)) $display("FAIL hazard_new_bias: got %h want all 12", o1); else n_pass++;
    n_total++; if (t1 != t0 + 1) $display("FAIL hazard_throughput: gap %0d want 1", t1 - t0); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [OW-1:0] res; int lat, extra;
    grp_num_cfg = '0; zero_point = 8'd0; act_mode = 2'd0;
    set_row(0, 7, 1, 0);
    m_ready = 1'b1; s_valid = 1'b1; s_data = fill_acc(1);
    repeat (6) begin @(posedge clk); #1; end
    n_total++; if (m_valid !== 1'b1) $display("FAIL midrst_pre: m_valid %b want 1", m_valid); else n_pass++;
    rst = 1'b0; #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid: got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== '0) $display("FAIL midrst_m_data: got %h want 0", m_data); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL midrst_s_ready: got %b want 0", s_ready); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; zero_point = 8'd3;
    // Tables are zero again, so scale 0 leaves only the zero point.
    send_get(fill_acc(100), 1'b0, res, lat);
    n_total++; if (lat != 5) $display("FAIL midrst_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (res !== fill_out(3)) $display("FAIL midrst_data: got %h want all 3", res); else n_pass++;
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (m_valid) extra++; end
    n_total++; if (extra != 0) $display("FAIL midrst_stale: got %0d extra beats want 0", extra); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_channels();
    test_groups();
    test_back_to_back();
    test_hazard();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
